// File: rtl/out_rate_cont_if.sv
// Signal bundle between the rate-control sequencer and its config front end / out_rate datapath.
// master drives requests and pipe status; slave is the sequencer.
interface out_rate_cont_if #(
  parameter int unsigned RATE_W = 8,
  parameter int unsigned CNT_W  = 6
);
  logic              cfg_valid;
  logic [RATE_W-1:0] cfg_rate;
  logic              cfg_ready;
  logic              cfg_done;
  logic              soft_flush;
  logic              samp_in;
  logic              samp_out;
  logic              fifo_empty;
  logic              hold_in;
  logic              flush;
  logic [RATE_W-1:0] rate;
  logic              busy;
  logic [CNT_W-1:0]  in_flight;
  logic              err;

  modport master (
    output cfg_valid, cfg_rate, soft_flush, samp_in, samp_out, fifo_empty,
    input  cfg_ready, cfg_done, hold_in, flush, rate, busy, in_flight, err
  );

  modport slave (
    input  cfg_valid, cfg_rate, soft_flush, samp_in, samp_out, fifo_empty,
    output cfg_ready, cfg_done, hold_in, flush, rate, busy, in_flight, err
  );
endinterface

// File: rtl/out_rate_cont.sv
// Sequences output-rate changes: stall upstream, drain pipe and FIFO, flush, apply, acknowledge.
// Optional drain timeout in HOLD enabled by defining OUT_RATE_CONT_TIMEOUT_EN.
module out_rate_cont #(
  parameter int unsigned RATE_W    = 8,
  parameter int unsigned CNT_W     = 6,
`ifdef OUT_RATE_CONT_TIMEOUT_EN
  parameter int unsigned TO_CYC    = 64,
`endif
  parameter int unsigned FLUSH_CYC = 2
) (
  input logic             clk,
  input logic             rst_n,
  out_rate_cont_if.slave  bus
);

  localparam int unsigned FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StFlush, StApply} state_e;

  state_e            state_q;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] pending_q;
  logic              from_hold_q;
  logic [FC_W-1:0]   flush_cnt_q;
  logic [CNT_W-1:0]  in_flight_q;
  logic              err_q;
  logic              drained;
  logic              timeout_hit;
  logic              inc, dec, at_max, at_zero;

  assign drained = (in_flight_q == '0) && bus.fifo_empty;

`ifdef OUT_RATE_CONT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Fires on the TO_CYC-th consecutive HOLD cycle that still has not drained.
  assign timeout_hit = (state_q == StHold) && !drained && (to_cnt_q == TO_W'(TO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (state_q == StHold) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rate_q      <= '0;
      pending_q   <= '0;
      from_hold_q <= 1'b0;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          flush_cnt_q <= '0;
          if (bus.soft_flush) begin
            state_q     <= StFlush;
            pending_q   <= rate_q;
            from_hold_q <= 1'b0;
          end else if (bus.cfg_valid) begin
            state_q     <= StHold;
            pending_q   <= bus.cfg_rate;
            from_hold_q <= 1'b1;
          end
        end
        StHold: begin
          if (drained || timeout_hit) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (flush_cnt_q == FC_W'(FLUSH_CYC - 1)) begin
            rate_q  <= pending_q;
            state_q <= from_hold_q ? StApply : StIdle;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        StApply: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign inc     = bus.samp_in && !bus.samp_out;
  assign dec     = bus.samp_out && !bus.samp_in;
  assign at_max  = (in_flight_q == '1);
  assign at_zero = (in_flight_q == '0);

  // Flush discards everything in the pipe, so it overrides counting and error detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (state_q == StFlush) begin
        in_flight_q <= '0;
      end else if (inc && !at_max) begin
        in_flight_q <= in_flight_q + 1'b1;
      end else if (dec && !at_zero) begin
        in_flight_q <= in_flight_q - 1'b1;
      end
      if (timeout_hit || ((state_q != StFlush) && ((inc && at_max) || (dec && at_zero)))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.cfg_ready = (state_q == StIdle) && !bus.soft_flush;
  assign bus.cfg_done  = (state_q == StApply);
  assign bus.hold_in   = (state_q != StIdle);
  assign bus.flush     = (state_q == StFlush);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rate      = rate_q;
  assign bus.in_flight = in_flight_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_out_rate_cont.sv
// Directed self-checking bench for out_rate_cont; expected values are hand-derived cycle by cycle.
module tb_out_rate_cont;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  out_rate_cont_if #(.RATE_W(8), .CNT_W(6)) bus ();

  out_rate_cont dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [19:0] obs;
    bus.cfg_valid = 0; bus.cfg_rate = 0; bus.soft_flush = 0;
    bus.samp_in = 0; bus.samp_out = 0; bus.fifo_empty = 1;
    rst_n = 0;
    #12;
    obs = {bus.busy, bus.hold_in, bus.flush, bus.cfg_done, bus.err, bus.rate, bus.in_flight,
           bus.cfg_ready};
    n_checks++;
    if (obs !== {5'b0, 8'd0, 6'd0, 1'b1}) $display("FAIL reset_state got=%h exp=%h", obs, 20'h1);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    tick;
  endtask

  task automatic test_basic;
    logic [3:0] obs;  // {hold_in, flush, cfg_done, busy}
    logic [3:0] exp_seq [4] = '{4'b1001, 4'b1101, 4'b1101, 4'b1011};
    bus.cfg_rate = 8'd3; bus.cfg_valid = 1;
    #1;
    n_checks++;
    if (bus.cfg_ready !== 1'b1) $display("FAIL basic_ready got=%b exp=1", bus.cfg_ready);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick;
      bus.cfg_valid = 0;
      obs = {bus.hold_in, bus.flush, bus.cfg_done, bus.busy};
      n_checks++;
      if (obs !== exp_seq[i]) $display("FAIL basic_seq[T+%0d] got=%b exp=%b", i + 1, obs, exp_seq[i]);
      else n_pass++;
    end
    n_checks++;
    if (bus.rate !== 8'd3) $display("FAIL basic_rate got=%0d exp=3", bus.rate);
    else n_pass++;
    tick;
    n_checks++;
    if ({bus.busy, bus.cfg_done, bus.rate} !== {2'b00, 8'd3})
      $display("FAIL basic_idle got busy=%b done=%b rate=%0d exp 0 0 3", bus.busy, bus.cfg_done, bus.rate);
    else n_pass++;
  endtask

  task automatic test_drain;
    bus.samp_in = 1;
    repeat (5) tick;
    bus.samp_in = 0;
    n_checks++;
    if (bus.in_flight !== 6'd5) $display("FAIL drain_fill got=%0d exp=5", bus.in_flight);
    else n_pass++;
    bus.cfg_rate = 8'd2; bus.cfg_valid = 1; bus.samp_out = 1;
    for (int i = 0; i < 5; i++) begin
      tick;
      bus.cfg_valid = 0;
      bus.samp_out = (i < 4);
      n_checks++;
      if ({bus.hold_in, bus.flush, bus.cfg_done, bus.in_flight} !== {3'b100, 6'(4 - i)})
        $display("FAIL drain_hold[%0d] got hold=%b flush=%b done=%b inflight=%0d exp 1 0 0 %0d",
                 i, bus.hold_in, bus.flush, bus.cfg_done, bus.in_flight, 4 - i);
      else n_pass++;
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      n_checks++;
      if ({bus.flush, bus.cfg_done, bus.rate} !== {2'b10, 8'd3})
        $display("FAIL drain_flush[%0d] got flush=%b done=%b rate=%0d exp 1 0 3",
                 i, bus.flush, bus.cfg_done, bus.rate);
      else n_pass++;
    end
    tick;
    n_checks++;
    if ({bus.flush, bus.cfg_done, bus.rate} !== {2'b01, 8'd2})
      $display("FAIL drain_apply got flush=%b done=%b rate=%0d exp 0 1 2",
               bus.flush, bus.cfg_done, bus.rate);
    else n_pass++;
    tick;
  endtask

  task automatic test_soft_flush;
    bit seen;
    bus.cfg_rate = 8'd4; bus.cfg_valid = 1;
    tick;
    bus.cfg_valid = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      seen = bus.cfg_done;
    end
    tick;
    n_checks++;
    if ({seen, bus.rate, bus.busy} !== {1'b1, 8'd4, 1'b0})
      $display("FAIL sf_setup got done=%b rate=%0d busy=%b exp 1 4 0", seen, bus.rate, bus.busy);
    else n_pass++;
    bus.soft_flush = 1; bus.cfg_valid = 1; bus.cfg_rate = 8'd7;
    #1;
    n_checks++;
    if (bus.cfg_ready !== 1'b0) $display("FAIL sf_ready_blocked got=%b exp=0", bus.cfg_ready);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      bus.soft_flush = 0;
      seen = seen | bus.cfg_done;
      n_checks++;
      if ({bus.flush, bus.cfg_ready, bus.rate} !== {2'b10, 8'd4})
        $display("FAIL sf_flush[%0d] got flush=%b ready=%b rate=%0d exp 1 0 4",
                 i, bus.flush, bus.cfg_ready, bus.rate);
      else n_pass++;
    end
    tick;
    seen = seen | bus.cfg_done;
    n_checks++;
    if ({seen, bus.busy, bus.cfg_ready, bus.rate} !== {3'b001, 8'd4})
      $display("FAIL sf_end got done_seen=%b busy=%b ready=%b rate=%0d exp 0 0 1 4",
               seen, bus.busy, bus.cfg_ready, bus.rate);
    else n_pass++;
    tick;
    bus.cfg_valid = 0;
    n_checks++;
    if ({bus.hold_in, bus.flush} !== 2'b10)
      $display("FAIL sf_accept_after got hold=%b flush=%b exp 1 0", bus.hold_in, bus.flush);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      seen = bus.cfg_done;
    end
    n_checks++;
    if ({seen, bus.rate} !== {1'b1, 8'd7})
      $display("FAIL sf_second_rate got done=%b rate=%0d exp 1 7", seen, bus.rate);
    else n_pass++;
    tick;
  endtask

  task automatic test_timeout;
    int  hold_cnt;
    bit  seen;
    bus.samp_in = 1;
    repeat (2) tick;
    bus.samp_in = 0;
    bus.cfg_rate = 8'd5; bus.cfg_valid = 1;
    tick;
    bus.cfg_valid = 0;
`ifdef OUT_RATE_CONT_TIMEOUT_EN
    hold_cnt = 1;
    for (int i = 0; i < 200 && !bus.flush; i++) begin
      tick;
      if (!bus.flush) hold_cnt++;
    end
    n_checks++;
    if ({bus.flush, bus.err} !== 2'b11 || hold_cnt != 64)
      $display("FAIL to_expire got flush=%b err=%b hold_cycles=%0d exp 1 1 64",
               bus.flush, bus.err, hold_cnt);
    else n_pass++;
    tick;
    n_checks++;
    if ({bus.flush, bus.in_flight} !== {1'b1, 6'd0})
      $display("FAIL to_inflight got flush=%b inflight=%0d exp 1 0", bus.flush, bus.in_flight);
    else n_pass++;
`else
    hold_cnt = 0;
    repeat (1000) tick;
    n_checks++;
    if ({bus.hold_in, bus.flush, bus.busy, bus.err, bus.in_flight} !== {4'b1010, 6'd2})
      $display("FAIL to_wait got hold=%b flush=%b busy=%b err=%b inflight=%0d exp 1 0 1 0 2",
               bus.hold_in, bus.flush, bus.busy, bus.err, bus.in_flight);
    else n_pass++;
    bus.samp_out = 1;
    repeat (2) tick;
    bus.samp_out = 0;
`endif
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick;
      seen = bus.cfg_done;
    end
    n_checks++;
    if ({seen, bus.rate} !== {1'b1, 8'd5})
      $display("FAIL to_done got done=%b rate=%0d exp 1 5 (hold_cycles=%0d)", seen, bus.rate, hold_cnt);
    else n_pass++;
    tick;
  endtask

  task automatic test_counter;
`ifndef OUT_RATE_CONT_TIMEOUT_EN
    n_checks++;
    if (bus.err !== 1'b0) $display("FAIL cnt_err_clean got=%b exp=0", bus.err);
    else n_pass++;
`endif
    bus.samp_in = 1;
    repeat (3) tick;
    bus.samp_out = 1;
    tick;
    n_checks++;
    if (bus.in_flight !== 6'd3) $display("FAIL cnt_both got=%0d exp=3", bus.in_flight);
    else n_pass++;
    bus.samp_in = 0;
    repeat (3) tick;
    n_checks++;
`ifdef OUT_RATE_CONT_TIMEOUT_EN
    if (bus.in_flight !== 6'd0) $display("FAIL cnt_drain got inflight=%0d exp 0", bus.in_flight);
`else
    if ({bus.in_flight, bus.err} !== {6'd0, 1'b0})
      $display("FAIL cnt_drain got inflight=%0d err=%b exp 0 0", bus.in_flight, bus.err);
`endif
    else n_pass++;
    tick;
    n_checks++;
    if ({bus.in_flight, bus.err} !== {6'd0, 1'b1})
      $display("FAIL cnt_underflow got inflight=%0d err=%b exp 0 1", bus.in_flight, bus.err);
    else n_pass++;
    bus.samp_out = 0;
    tick;
    n_checks++;
    if (bus.err !== 1'b1) $display("FAIL cnt_err_sticky got=%b exp=1", bus.err);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit seen;
    bus.cfg_rate = 8'd9; bus.cfg_valid = 1;
    tick;
    bus.cfg_valid = 0;
    tick;
    n_checks++;
    if (bus.flush !== 1'b1) $display("FAIL rm_in_flush got=%b exp=1", bus.flush);
    else n_pass++;
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({bus.flush, bus.busy, bus.hold_in, bus.err, bus.rate} !== {4'b0000, 8'd0})
      $display("FAIL rm_async got flush=%b busy=%b hold=%b err=%b rate=%0d exp 0 0 0 0 0",
               bus.flush, bus.busy, bus.hold_in, bus.err, bus.rate);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      seen = seen | bus.cfg_done | bus.busy;
    end
    n_checks++;
    if ({seen, bus.rate} !== {1'b0, 8'd0})
      $display("FAIL rm_after got done_or_busy=%b rate=%0d exp 0 0", seen, bus.rate);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_drain;
    test_soft_flush;
    test_timeout;
    test_counter;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
